// File: rtl/completion_buffer.sv
// Completion buffer: in-order FIFO behind the global-stall address pipeline.
// Holds {address, id, kill} entries and retires flushed ones in place.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module completion_buffer #(
  parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int ID_WIDTH      = `ID_WIDTH,
  parameter int DEPTH         = 8,
  parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  input  logic                     in_flush,
  input  logic [ID_WIDTH-1:0]      in_flush_id,
  output logic                     stall_out,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_WIDTH-1:0]     occupancy,
  output logic [15:0]              drop_count
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [ID_WIDTH-1:0]      id_q   [DEPTH];
  logic [DEPTH-1:0]         kill_q;
  logic [PW-1:0]            wptr_q;
  logic [PW-1:0]            rptr_q;
  logic [CNT_WIDTH-1:0]     count_q;
  logic [15:0]              drop_q;

  logic        full;
  logic        empty;
  logic        hit_in;
  logic        refuse;
  logic        push;
  logic        head_kill;
  logic        pop;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_nxt;

  // Handshake, push/pop and drop accounting from registered state
  always_comb begin
    full      = (count_q == CNT_WIDTH'(DEPTH));
    empty     = (count_q == '0);
    hit_in    = in_flush && (in_id == in_flush_id);
    refuse    = in_valid && !full && hit_in;
    push      = in_valid && !full && !hit_in;
    head_kill = !empty && kill_q[rptr_q];
    out_valid = !empty && !kill_q[rptr_q];
    pop       = (out_valid && out_ready) || head_kill;
    drop_inc  = 2'(head_kill) + 2'(refuse);
    drop_sum  = {1'b0, drop_q} + 17'(drop_inc);
    drop_nxt  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    stall_out = full;
    occupancy = count_q;
    drop_count = drop_q;
    out_address = empty ? '0 : addr_q[rptr_q];
    out_id      = empty ? '0 : id_q[rptr_q];
  end

  // Entry storage, kill marking, pointers, count and drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        id_q[i]   <= '0;
      end
      kill_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (in_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (id_q[i] == in_flush_id)
            kill_q[i] <= 1'b1;
        end
      end
      if (push) begin
        addr_q[wptr_q] <= in_address;
        id_q[wptr_q]   <= in_id;
        kill_q[wptr_q] <= 1'b0;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CNT_WIDTH'(push)
                         - CNT_WIDTH'(pop);
      drop_q  <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer.
// Steps are linear; each check is an immediate assertion.
module tb_completion_buffer;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] in_address;
  logic [IW-1:0] in_id;
  logic          in_valid;
  logic          in_flush;
  logic [IW-1:0] in_flush_id;
  logic          stall_out;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] occupancy;
  logic [15:0]   drop_count;

  int compared;
  int mismatched;

  completion_buffer #(
    .ADDRESS_WIDTH(AW),
    .ID_WIDTH(IW),
    .DEPTH(D),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_address(in_address),
    .in_id(in_id),
    .in_valid(in_valid),
    .in_flush(in_flush),
    .in_flush_id(in_flush_id),
    .stall_out(stall_out),
    .out_address(out_address),
    .out_id(out_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset_n     = 1'b0;
    in_address  = '0;
    in_id       = '0;
    in_valid    = 1'b0;
    in_flush    = 1'b0;
    in_flush_id = '0;
    out_ready   = 1'b0;

    // reset
    step();
    step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_addr", out_address, 0);
    chk("rst_id", 32'(out_id), 0);
    reset_n = 1'b1;

    // single push
    in_valid = 1'b1;
    in_id = 4'd3;
    in_address = 32'h15;
    step();
    in_valid = 1'b0;
    chk("p1_valid", 32'(out_valid), 1);
    chk("p1_id", 32'(out_id), 3);
    chk("p1_addr", out_address, 32'h15);
    chk("p1_occ", 32'(occupancy), 1);
    chk("p1_stall", 32'(stall_out), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("p1_drain", 32'(occupancy), 0);

    // fill to full
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_id = IW'(i);
      in_address = 32'h100 + 32'(i);
      step();
    end
    in_id = 4'd9;
    in_address = 32'h199;
    chk("full_stall", 32'(stall_out), 1);
    chk("full_occ", 32'(occupancy), 8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_occ", 32'(occupancy), 8);
      chk("full_hold_id", 32'(out_id), 0);
    end
    out_ready = 1'b1;
    chk("full_pop_v", 32'(out_valid), 1);
    chk("full_pop_id", 32'(out_id), 0);
    step();
    out_ready = 1'b0;
    chk("full_after_stall", 32'(stall_out), 0);
    chk("full_after_occ", 32'(occupancy), 7);
    chk("full_after_id", 32'(out_id), 1);
    step();
    in_valid = 1'b0;
    chk("cap9_occ", 32'(occupancy), 8);
    chk("cap9_stall", 32'(stall_out), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_id", 32'(out_id),
          (i == 8) ? 32'd9 : 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_occ", 32'(occupancy), 0);

    // streaming with wrap
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_id = IW'(k);
      in_address = 32'h200 + 32'(k);
      step();
      chk("wrap_id", 32'(out_id), 32'(k));
      chk("wrap_addr", out_address, 32'h200 + 32'(k));
      chk("wrap_occ", 32'(occupancy), 1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("wrap_empty", 32'(occupancy), 0);
    chk("wrap_drop", 32'(drop_count), 0);

    // flush stored entries
    in_valid = 1'b1;
    in_id = 4'd1;
    in_address = 32'h301;
    step();
    in_id = 4'd2;
    in_address = 32'h302;
    step();
    in_id = 4'd1;
    in_address = 32'h303;
    step();
    in_id = 4'd4;
    in_address = 32'h304;
    step();
    in_valid = 1'b0;
    in_flush = 1'b1;
    in_flush_id = 4'd1;
    step();
    in_flush = 1'b0;
    chk("fl_occ", 32'(occupancy), 4);
    chk("fl_drop0", 32'(drop_count), 0);
    chk("fl_headkill", 32'(out_valid), 0);
    out_ready = 1'b1;
    step();
    chk("fl_d1", 32'(drop_count), 1);
    chk("fl_v2", 32'(out_valid), 1);
    chk("fl_id2", 32'(out_id), 2);
    step();
    chk("fl_killed2", 32'(out_valid), 0);
    chk("fl_occ2", 32'(occupancy), 2);
    step();
    chk("fl_id4", 32'(out_id), 4);
    chk("fl_v4", 32'(out_valid), 1);
    chk("fl_d2", 32'(drop_count), 2);
    step();
    out_ready = 1'b0;
    chk("fl_empty", 32'(occupancy), 0);
    chk("fl_drop", 32'(drop_count), 2);

    // flush colliding with an arrival
    in_valid = 1'b1;
    in_id = 4'd6;
    in_address = 32'h406;
    step();
    chk("col_pre", 32'(occupancy), 1);
    in_id = 4'd5;
    in_address = 32'h405;
    in_flush = 1'b1;
    in_flush_id = 4'd5;
    step();
    in_valid = 1'b0;
    in_flush = 1'b0;
    chk("col_occ", 32'(occupancy), 1);
    chk("col_drop", 32'(drop_count), 3);
    chk("col_head", 32'(out_id), 6);

    // flush of the head during handshake
    out_ready = 1'b1;
    in_flush = 1'b1;
    in_flush_id = 4'd6;
    chk("hs_valid", 32'(out_valid), 1);
    chk("hs_id", 32'(out_id), 6);
    step();
    in_flush = 1'b0;
    out_ready = 1'b0;
    chk("hs_occ", 32'(occupancy), 0);
    chk("hs_drop", 32'(drop_count), 3);

    // async reset mid-operation
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_id = IW'(10 + i);
      in_address = 32'h500 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("ar_pre", 32'(occupancy), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_stall", 32'(stall_out), 0);
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_drop", 32'(drop_count), 0);
    step();
    reset_n = 1'b1;
    in_valid = 1'b1;
    in_id = 4'd7;
    in_address = 32'h77;
    step();
    in_valid = 1'b0;
    chk("ar_new_id", 32'(out_id), 7);
    chk("ar_new_addr", out_address, 32'h77);
    chk("ar_new_occ", 32'(occupancy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/completion_buffer.md
Name: completion_buffer

Overview:
- Sits directly downstream of the global-stall address pipeline.
- Captures each valid {address, id} leaving the pipeline output register into a DEPTH-entry FIFO and presents the entries in order to the consumer over a valid/ready handshake.
- Drives the pipeline's global stall when it cannot accept more entries.
- Applies ID-tagged flushes: matching entries are removed from the FIFO, and a matching arrival is not captured.

Parameters:
ADDRESS_WIDTH, `ADDRESS_WIDTH, width of the address field
ID_WIDTH, `ID_WIDTH, width of the request ID
DEPTH, 8, number of FIFO entries; power of two, at least 2
CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  sole clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_address  input  ADDRESS_WIDTH  address from the pipeline output
in_id  input  ID_WIDTH  ID from the pipeline output
in_valid  input  1  pipeline output holds a valid entry
in_flush  input  1  single-cycle flush request
in_flush_id  input  ID_WIDTH  ID to flush
stall_out  output  1  drives the pipeline in_stall
out_address  output  ADDRESS_WIDTH  head entry address
out_id  output  ID_WIDTH  head entry ID
out_valid  output  1  head entry is live and presentable
out_ready  input  1  consumer accepts the head entry
occupancy  output  CNT_WIDTH  stored entries, including killed ones
drop_count  output  16  saturating count of flushed entries

Behaviour:
- Reset (reset_n low, async): read/write pointers, count and all kill bits cleared. stall_out=0, out_valid=0, out_address=0, out_id=0, occupancy=0, drop_count=0. A reset mid-operation discards all entries immediately.
- Storage: per entry {address, id, kill}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is the full/empty source.
- full = (count == DEPTH). stall_out = full, combinational from registered count only; there is no path from out_ready.
- Full is conservative: while full, no push occurs even if a pop happens the same cycle.
- Push: when in_valid && !stall_out && !(in_flush && in_id==in_flush_id), write {in_address, in_id, kill=0} at the write pointer.
  - Under global stall the pipeline output register holds its value, so a held entry is captured exactly once: on the first non-stalled cycle it is presented.
- Flush: when in_flush is high, at the next edge set kill=1 on every stored entry whose id==in_flush_id.
  - An arriving entry with in_id==in_flush_id in the same cycle is not written; drop_count+1.
  - A flush ID that matches nothing is a no-op.
- Head: out_valid = (count!=0) && !kill[head]. out_address and out_id are combinational from the head entry, and read 0 when count==0.
- Pop: occurs when (out_valid && out_ready) or (count!=0 && kill[head]). A killed head is discarded automatically, one per cycle, without asserting out_valid; drop_count+1.
- Flush hitting the head in the same cycle it is handshaken: the transfer completes, the pop is normal, and no drop is counted.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Same-cycle drop increments: a killed-head discard and a refused arrival in the same cycle add 2 to drop_count.
- drop_count saturates at 16'hFFFF.
- Latency: an entry pushed at edge N is visible on out_valid after edge N (zero added bubble).
- occupancy = count.
- Single always block for sequential state. No combinational loops.

Test Plan:
- Reset then a single push: reset_n=0 for 2 cycles, then in_valid=1, id=3, addr=0x15 for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_id=3, out_address=0x15, occupancy=1, stall_out=0.
- Fill to full, DEPTH=8: 8 consecutive pushes with out_ready=0 -> stall_out=1 after the 8th edge. A 9th in_valid held 3 cycles is not captured. Raise out_ready for 1 cycle -> id of the first entry pops, stall_out drops, the held 9th entry is captured exactly once, occupancy=8.
- In-order drain with wrap: push ids 0..11 while popping continuously (out_ready=1) -> ids emerge 0..11 in order, pointers wrap, occupancy never exceeds 2, drop_count=0.
- Flush of stored entries: store ids 1,2,1,4 with out_ready=0, then pulse in_flush with id=1. Set out_ready=1 -> consumer sees only ids 2 and 4, drop_count=2, occupancy reaches 0.
- Flush colliding with an arrival: in_valid=1, in_id=5, in_flush=1, in_flush_id=5 in the same cycle -> nothing written, occupancy unchanged, drop_count+1. Flush of the head while it is handshaken -> the transfer completes and drop_count does not increment.
- Asynchronous reset mid-operation: with 5 entries stored, deassert reset_n between clock edges -> out_valid, stall_out, occupancy and drop_count are 0 immediately. After release, a new push is output first.
